// File: rtl/route_sequencer_if.sv
// Handshake/bus bundle between the route sequencer and its environment:
// table programming, tracker input, turn-block handshake and status outputs.
interface route_sequencer_if #(
  parameter int NSTEPS = 8
);
  localparam int IW = $clog2(NSTEPS);

  logic          start;
  logic          abort;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic [2:0]    detect;
  logic          doneL;
  logic          doneR;
  logic          turn_err;
  logic          enL;
  logic          enR;
  logic [1:0]    count;
  logic [1:0]    mode;
  logic [IW-1:0] step_idx;
  logic          busy;
  logic          finished;
  logic          error;

  modport master (
    output start, abort, wr_en, wr_addr, wr_data, detect, doneL, doneR, turn_err,
    input  enL, enR, count, mode, step_idx, busy, finished, error
  );

  modport slave (
    input  start, abort, wr_en, wr_addr, wr_data, detect, doneL, doneR, turn_err,
    output enL, enR, count, mode, step_idx, busy, finished, error
  );
endinterface

// File: rtl/route_sequencer.sv
// Route-level controller: steps through a programmable junction-action table,
// arms the left/right turn blocks and aborts stalled legs with a watchdog.
//
// state   | meaning
// IDLE    | stopped, waiting for start
// FETCH   | latch table entry idx; END finishes the route
// FOLLOW  | line following, waiting for a qualified junction
// CROSS   | driving straight over a junction until it clears
// TURN    | matching turn block armed, waiting for its done
// ADVANCE | step to next entry or finish after the last one
// DONE    | route complete
// FAULT   | watchdog expiry or turn error, held until abort
module route_sequencer #(
  parameter int NSTEPS  = 8,
  parameter int TIMEOUT = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  route_sequencer_if.slave bus
);
  localparam int IW = $clog2(NSTEPS);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] DIR_END      = 2'b00;
  localparam logic [1:0] DIR_LEFT     = 2'b01;
  localparam logic [1:0] DIR_STRAIGHT = 2'b11;

  localparam logic [1:0] MODE_STOP   = 2'd0;
  localparam logic [1:0] MODE_FOLLOW = 2'd1;
  localparam logic [1:0] MODE_LEFT   = 2'd2;
  localparam logic [1:0] MODE_RIGHT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, FETCH, FOLLOW, CROSS, TURN, ADVANCE, DONE, FAULT
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    route_tbl [NSTEPS];
  logic [IW-1:0] idx, idx_nx;
  logic [WW-1:0] wd, wd_nx;
  logic [1:0]    cur_dir, cur_cnt;
  logic          start_q, det_prev, junction_q;
  logic          done_match, at_junction;
  logic          en_l_nx, en_r_nx, busy_nx, finished_nx, error_nx;
  logic [1:0]    mode_nx, count_nx;

  assign at_junction = (bus.detect == 3'b111);
  assign done_match  = (cur_dir == DIR_LEFT) ? bus.doneL : bus.doneR;
  assign bus.step_idx = idx;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wd_nx    = wd;
    // watchdog is a down-counter; zero is terminal count
    if ((state inside {FOLLOW, CROSS, TURN}) && (wd != '0))
      wd_nx = wd - 1'b1;
    unique case (state)
      IDLE, DONE: begin
        if (start_q) begin
          idx_nx   = '0;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        if (route_tbl[idx][3:2] == DIR_END) begin
          state_nx = DONE;
        end else begin
          state_nx = FOLLOW;
          wd_nx    = WW'(TIMEOUT - 1);
        end
      end
      FOLLOW: begin
        if (junction_q) begin
          wd_nx    = WW'(TIMEOUT - 1);
          state_nx = (cur_dir == DIR_STRAIGHT) ? CROSS : TURN;
        end else if (wd == '0) begin
          state_nx = FAULT;
        end
      end
      CROSS: begin
        if (!at_junction)   state_nx = ADVANCE;
        else if (wd == '0)  state_nx = FAULT;
      end
      TURN: begin
        if (bus.turn_err)   state_nx = FAULT;
        else if (done_match) state_nx = ADVANCE;
        else if (wd == '0)  state_nx = FAULT;
      end
      ADVANCE: begin
        if (idx == IW'(NSTEPS - 1)) begin
          state_nx = DONE;
        end else begin
          idx_nx   = idx + 1'b1;
          state_nx = FETCH;
        end
      end
      FAULT: state_nx = FAULT;
    endcase
    if (bus.abort) begin
      state_nx = IDLE;
      idx_nx   = '0;
      wd_nx    = '0;
    end

    // outputs are registered from the next state so they line up with it
    mode_nx     = MODE_STOP;
    en_l_nx     = 1'b0;
    en_r_nx     = 1'b0;
    count_nx    = 2'd0;
    busy_nx     = state_nx inside {FETCH, FOLLOW, CROSS, TURN, ADVANCE};
    finished_nx = (state_nx == DONE);
    error_nx    = (state_nx == FAULT);
    if (state_nx == FOLLOW || state_nx == CROSS) begin
      mode_nx = MODE_FOLLOW;
    end else if (state_nx == TURN) begin
      count_nx = cur_cnt;
      if (cur_dir == DIR_LEFT) begin
        mode_nx = MODE_LEFT;
        en_l_nx = 1'b1;
      end else begin
        mode_nx = MODE_RIGHT;
        en_r_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      wd           <= '0;
      cur_dir      <= DIR_END;
      cur_cnt      <= 2'd0;
      start_q      <= 1'b0;
      det_prev     <= 1'b0;
      junction_q   <= 1'b0;
      bus.enL      <= 1'b0;
      bus.enR      <= 1'b0;
      bus.count    <= 2'd0;
      bus.mode     <= MODE_STOP;
      bus.busy     <= 1'b0;
      bus.finished <= 1'b0;
      bus.error    <= 1'b0;
      for (int i = 0; i < NSTEPS; i++) route_tbl[i] <= 4'd0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      wd           <= wd_nx;
      start_q      <= bus.start;
      bus.enL      <= en_l_nx;
      bus.enR      <= en_r_nx;
      bus.count    <= count_nx;
      bus.mode     <= mode_nx;
      bus.busy     <= busy_nx;
      bus.finished <= finished_nx;
      bus.error    <= error_nx;
      if (state == FETCH) begin
        cur_dir <= route_tbl[idx][3:2];
        cur_cnt <= route_tbl[idx][1:0];
      end
      // junction needs two consecutive all-ones samples while following
      if (state == FOLLOW) begin
        det_prev   <= at_junction;
        junction_q <= at_junction && det_prev;
      end else begin
        det_prev   <= 1'b0;
        junction_q <= 1'b0;
      end
      if (bus.wr_en && !bus.busy && (int'(bus.wr_addr) < NSTEPS))
        route_tbl[bus.wr_addr] <= bus.wr_data;
    end
  end
endmodule
